pipe_skid_reg: RTL and testbench
================================

// Module: pipe_skid_reg
// PURPOSE
//  Elastic pipeline register: n-bit valid/ready stage giving one-cycle latency at full throughput.
//  Receiver side accepts words from an upstream stage; transmitter side presents them downstream.
//  IN_READY and OUT_VALID/OUT_DATA come straight from flops, breaking combinational ready/valid paths.
//  Drop-in stage between datapath blocks; a two-entry buffer (main + skid) absorbs one stall cycle.
// PARAMETERS
//  n  32  data width in bits
// PORTS
//  CLOCK      in   1   single clock; all state changes on rising edge
//  RESET      in   1   synchronous, active-high; highest priority
//  FLUSH      in   1   synchronous discard of all held words; priority below RESET
//  IN_VALID   in   1   upstream word on IN_DATA is valid
//  IN_READY   out  1   stage can accept; transfer when IN_VALID && IN_READY at edge
//  IN_DATA    in   n   upstream word
//  OUT_VALID  out  1   OUT_DATA holds a valid word
//  OUT_READY  in   1   downstream accepts; transfer when OUT_VALID && OUT_READY at edge
//  OUT_DATA   out  n   word presented downstream (main register)
//  COUNT      out  2   words held: 0, 1 or 2
// BEHAVIOUR
//  - Reset: state EMPTY, main=0, skid=0, OUT_VALID=0, OUT_DATA=0, COUNT=0; IN_READY=0 while RESET=1.
//  - States (COUNT mirrors): EMPTY(0) IN_READY=1 OUT_VALID=0; BUSY(1) IN_READY=1 OUT_VALID=1;
//    FULL(2) IN_READY=0 OUT_VALID=1.
//  - in_xfer = IN_VALID&&IN_READY; out_xfer = OUT_VALID&&OUT_READY.
//  - EMPTY: in_xfer -> main<=IN_DATA, BUSY. Otherwise hold.
//  - BUSY: in&&out -> main<=IN_DATA, stay BUSY. in&&!out -> skid<=IN_DATA, FULL.
//    !in&&out -> EMPTY. neither -> hold.
//  - FULL: out_xfer -> main<=skid, BUSY. IN_VALID ignored (IN_READY=0). Else hold.
//  - Latency: word accepted at edge k is on OUT_DATA with OUT_VALID=1 after edge k; may leave at edge k+1.
//  - Throughput: one word/cycle sustained while OUT_READY=1; no bubbles.
//  - OUT_DATA/OUT_VALID must not change while OUT_VALID=1 && OUT_READY=0 (except RESET/FLUSH).
//  - Order strictly FIFO; no word dropped or duplicated.
//  - FLUSH=1: next state EMPTY, COUNT=0, OUT_VALID=0; any in_xfer/out_xfer that cycle is discarded;
//    data registers need not be cleared. IN_READY=1 in the flush cycle unless state is FULL.
//  - RESET mid-transfer: all held words lost; IN_READY=0 for the reset cycle, 1 on first cycle after.
//  - No combinational path from IN_VALID/OUT_READY to IN_READY/OUT_VALID/OUT_DATA.
//  - OUT_VALID=0: OUT_DATA is don't-care for checkers.
// STRUCTURE
//  - Package pipe_pkg: typedef enum logic [1:0] {EMPTY=2'd0, BUSY=2'd1, FULL=2'd2} pipe_state_t;
//    COUNT driven directly from state encoding.
//  - Sub-module dff_en: n-bit register with load enable and sync active-high reset (CLOCK, RESET,
//    EN, D, Q); instantiated twice, main and skid.
//  - Top holds the state register and next-state/enable logic only.
// TESTING
//  1 Reset: RESET=1 two cycles, IN_VALID=1 -> IN_READY=0, OUT_VALID=0, COUNT=0; after release IN_READY=1.
//  2 Single word: IN_DATA=32'h0000_8000 one cycle, OUT_READY=1 -> OUT_VALID=1 with 8000 next cycle, then EMPTY.
//  3 Stream: IN_DATA=1..16 back-to-back, OUT_READY=1 -> outputs 1..16 on consecutive cycles, COUNT stays 1.
//  4 Stall: OUT_READY=0, send A=32'hA, B=32'hB -> COUNT=2, IN_READY=0, OUT_DATA=A held;
//    C offered while full is not taken; OUT_READY=1 -> A, B, C in order.
//  5 Flush while FULL (A,B held), IN_VALID=1 with D -> next cycle COUNT=0, OUT_VALID=0, D not delivered.
//  6 Random IN_VALID/OUT_READY 2000 cycles vs scoreboard queue -> in-order, no loss, no duplicate,
//    OUT_DATA stable during stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: occupancy state and count helper.
package pipe_pkg;

    localparam int unsigned COUNT_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // The state encoding equals the number of held words.
    function automatic logic [COUNT_W-1:0] state_count(input pipe_state_t s);
        return COUNT_W'(s);
    endfunction

endpackage

// File: rtl/dff_en.sv
// n-bit register with load enable and synchronous active-high reset to zero.
module dff_en #(
    parameter int unsigned n = 32
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic         EN,
    input  logic [n-1:0] D,
    output logic [n-1:0] Q
);

    logic [n-1:0] q_q;
    logic [n-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (EN) begin
            q_d = D;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready pipeline register: main + skid buffer, one-cycle latency, full throughput.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               FLUSH,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [n-1:0]       IN_DATA,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [n-1:0]       OUT_DATA,
    output logic [COUNT_W-1:0] COUNT
);

    pipe_state_t  state_q;
    pipe_state_t  state_d;
    logic         in_ready_q;
    logic         in_ready_d;
    logic         out_valid_q;
    logic         out_valid_d;
    logic         main_en;
    logic         skid_en;
    logic         main_from_skid;
    logic [n-1:0] main_d;
    logic [n-1:0] main_q;
    logic [n-1:0] skid_q;
    logic         in_xfer;
    logic         out_xfer;

    assign in_xfer  = IN_VALID && in_ready_q;
    assign out_xfer = out_valid_q && OUT_READY;

    // Next-state and register-load control; FLUSH discards everything held this cycle.
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_en = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_en = 1'b1;
                end else if (in_xfer) begin
                    skid_en = 1'b1;
                    state_d = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (FLUSH) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    assign main_d = main_from_skid ? skid_q : IN_DATA;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    dff_en #(.n(n)) u_main (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .EN    (main_en),
        .D     (main_d),
        .Q     (main_q)
    );

    dff_en #(.n(n)) u_skid (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .EN    (skid_en),
        .D     (IN_DATA),
        .Q     (skid_q)
    );

    // Ready is held low for as long as reset is asserted.
    assign IN_READY  = in_ready_q && !RESET;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = main_q;
    assign COUNT     = state_count(state_q);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed scenarios plus randomized valid/ready traffic.
module tb_pipe_skid_reg;

    localparam int unsigned N = 32;

    logic         CLOCK;
    logic         RESET;
    logic         FLUSH;
    logic         IN_VALID;
    logic         IN_READY;
    logic [N-1:0] IN_DATA;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [N-1:0] OUT_DATA;
    logic [1:0]   COUNT;

    int total = 0;
    int bad   = 0;

    // Reference model: the stage is a two-deep FIFO; exp_q holds accepted, undelivered words.
    logic [N-1:0] exp_q[$];
    int           cnt = 0;

    pipe_skid_reg #(.n(N)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .FLUSH     (FLUSH),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .COUNT     (COUNT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, check handshake/occupancy, then advance the model past the edge.
    task automatic cycle(input logic rst, input logic fl, input logic iv,
                         input logic [N-1:0] d, input logic ordy);
        logic acc;
        logic dlv;
        RESET     = rst;
        FLUSH     = fl;
        IN_VALID  = iv;
        IN_DATA   = d;
        OUT_READY = ordy;
        #1;
        check("in_ready",  N'(IN_READY),  N'(!rst && cnt < 2));
        check("out_valid", N'(OUT_VALID), N'(cnt > 0));
        check("count",     N'(COUNT),     N'(cnt));
        @(posedge CLOCK);
        #1;
        if (rst || fl) begin
            cnt = 0;
            exp_q.delete();
        end else begin
            acc = iv && (cnt < 2);
            dlv = ordy && (cnt > 0);
            cnt = cnt + int'(acc) - int'(dlv);
            if (acc) exp_q.push_back(d);
        end
    endtask

    // Monitor: inputs are stable at the falling edge, so a transfer seen here happens at the next rise.
    logic         prev_stall = 1'b0;
    logic [N-1:0] prev_data  = '0;

    always @(negedge CLOCK) begin
        if (RESET === 1'b0 && FLUSH === 1'b0) begin
            if (prev_stall) begin
                check("stall_valid", N'(OUT_VALID), N'(1));
                check("stall_data",  OUT_DATA,      prev_data);
            end
            if (OUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got %h want no word at %0t", OUT_DATA, $time);
                end else begin
                    check("out_data", OUT_DATA, exp_q.pop_front());
                end
            end
            prev_stall = OUT_VALID && !OUT_READY;
            prev_data  = OUT_DATA;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        logic         r_rst;
        logic         r_fl;
        logic         r_iv;
        logic         r_or;
        RESET     = 1'b1;
        FLUSH     = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = '0;
        OUT_READY = 1'b0;
        @(posedge CLOCK);
        #1;
        cnt = 0;
        exp_q.delete();

        // Reset held a second cycle with IN_VALID high, then released.
        cycle(1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        check("reset_out_data", OUT_DATA, '0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Single word.
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_8000, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Back-to-back stream.
        for (int i = 1; i <= 16; i++) cycle(1'b0, 1'b0, 1'b1, N'(i), 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Stall: A and B fill the stage, C waits until space opens.
        cycle(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
        check("full_out_data", OUT_DATA, 32'hA);
        cycle(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Flush while full with D offered.
        cycle(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 32'hD, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 2000; i++) begin
            r_rst = ($urandom_range(0, 499) == 0);
            r_fl  = ($urandom_range(0, 63) == 0);
            r_iv  = ($urandom_range(0, 3) != 0);
            r_or  = ($urandom_range(0, 2) != 0);
            cycle(r_rst, r_fl, r_iv, $urandom, r_or);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
